icetap_seq_capture: RTL and testbench

ICETAP_SEQ_CAPTURE -- requirements
Module: icetap_seq_capture

---
 rtl/icetap_seq_capture_if.sv | 41 ++++
 rtl/icetap_seq_capture.sv | 228 ++++++++++++++++++++++
 tb/tb_icetap_seq_capture.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icetap_seq_capture_if.sv
// Bus interface for icetap_seq_capture.
// Groups the probe input, command pulses, trigger/store configuration,
// status outputs and the buffer readout port. The master side (host or
// bench) drives probes/commands/configuration and the read address; the
// slave side (the capture core) returns status and read data.
interface icetap_seq_capture_if #(
    parameter int NR_SIGNALS = 16,
    parameter int NR_STAGES  = 4,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16,
    parameter int SW         = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1
);
    logic [NR_SIGNALS-1:0]             signals_in;
    logic                              cmd_start;
    logic                              cmd_abort;
    logic [3*NR_SIGNALS-1:0]           store_cond;
    logic [3*NR_SIGNALS*NR_STAGES-1:0] trig_cond;
    logic [CNT_W*NR_STAGES-1:0]        trig_count;
    logic [SW-1:0]                     last_stage;
    logic [CNT_W-1:0]                  post_count;
    logic [1:0]                        state;
    logic [SW-1:0]                     stage;
    logic [ADDR_W-1:0]                 wr_addr;
    logic                              wrapped;
    logic [ADDR_W-1:0]                 trig_addr;
    logic                              done;
    logic [ADDR_W-1:0]                 rd_addr;
    logic [NR_SIGNALS-1:0]             rd_data;

    modport master (
        output signals_in, cmd_start, cmd_abort, store_cond, trig_cond,
               trig_count, last_stage, post_count, rd_addr,
        input  state, stage, wr_addr, wrapped, trig_addr, done, rd_data
    );

    modport slave (
        input  signals_in, cmd_start, cmd_abort, store_cond, trig_cond,
               trig_count, last_stage, post_count, rd_addr,
        output state, stage, wr_addr, wrapped, trig_addr, done, rd_data
    );
endinterface

// File: rtl/icetap_seq_capture.sv
// Multi-stage triggered logic-analyser capture core.
// A sequencer walks through NR_STAGES trigger conditions; each stage must
// match trig_count times before advancing. Completing the last stage is the
// trigger: that sample is always stored and post_count further qualified
// samples are captured into a circular buffer before the core goes DONE.
// Ports:
//   clk    - capture clock, all logic on its rising edge
//   reset_ - asynchronous active-low reset
//   bus    - slave side of icetap_seq_capture_if (probes, commands,
//            configuration, status and buffer readout)
module icetap_seq_capture #(
    parameter int NR_SIGNALS = 16,
    parameter int NR_STAGES  = 4,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16,
    parameter int SW         = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1
) (
    input  logic                 clk,
    input  logic                 reset_,
    icetap_seq_capture_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW3   = 3 * NR_SIGNALS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Per-signal condition code evaluation; edge codes need a valid prior sample.
    function automatic logic bit_match(input logic [2:0] code, input logic cur,
                                       input logic prv, input logic edge_ok);
        logic m;
        case (code)
            3'd1:    m = cur;
            3'd2:    m = ~cur;
            3'd3:    m = edge_ok & cur & ~prv;
            3'd4:    m = edge_ok & ~cur & prv;
            3'd5:    m = edge_ok & (cur ^ prv);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // Whole-vector match: every signal's condition must hold.
    function automatic logic vec_match(input logic [CW3-1:0] cond,
                                       input logic [NR_SIGNALS-1:0] cur,
                                       input logic [NR_SIGNALS-1:0] prv,
                                       input logic edge_ok);
        logic m;
        m = 1'b1;
        for (int i = 0; i < NR_SIGNALS; i++) begin
            m = m & bit_match(cond[3*i +: 3], cur[i], prv[i], edge_ok);
        end
        return m;
    endfunction

    state_t                r_state;
    logic [SW-1:0]         r_stage;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic                  r_wrapped;
    logic [ADDR_W-1:0]     r_trig_addr;
    logic                  r_done;
    logic [CNT_W-1:0]      r_occ_cnt;
    logic [CNT_W-1:0]      r_post_cnt;
    logic [NR_SIGNALS-1:0] r_prev;
    logic                  r_prev_valid;
    logic [NR_SIGNALS-1:0] r_mem [DEPTH];
    logic [NR_SIGNALS-1:0] r_rd_data;

    state_t                w_state_nxt;
    logic [SW-1:0]         w_stage_nxt;
    logic [ADDR_W-1:0]     w_wr_addr_nxt;
    logic                  w_wrapped_nxt;
    logic [ADDR_W-1:0]     w_trig_addr_nxt;
    logic [CNT_W-1:0]      w_occ_nxt;
    logic [CNT_W-1:0]      w_post_nxt;
    logic                  w_prev_valid_nxt;
    logic                  w_wr_en;
    logic                  w_store_hit;
    logic                  w_trig_hit;
    logic [CW3-1:0]        w_stage_cond;
    logic [CNT_W-1:0]      w_stage_cnt;
    logic [CNT_W-1:0]      w_need;
    logic [CNT_W:0]        w_occ_inc;
    logic [SW-1:0]         w_eff_last;
    logic [CNT_W-1:0]      w_post_clamp;

    // Select the active stage's configuration and derive the compare operands.
    always_comb begin
        w_stage_cond = bus.trig_cond[CW3*int'(r_stage) +: CW3];
        w_stage_cnt  = bus.trig_count[CNT_W*int'(r_stage) +: CNT_W];
        // A programmed count of zero behaves like one.
        w_need       = (w_stage_cnt == {CNT_W{1'b0}}) ? CNT_W'(1) : w_stage_cnt;
        w_occ_inc    = {1'b0, r_occ_cnt} + (CNT_W+1)'(1);
        // Out-of-range last_stage collapses onto the highest real stage.
        w_eff_last   = (int'(bus.last_stage) >= NR_STAGES) ? SW'(NR_STAGES-1)
                                                           : bus.last_stage;
        // Post-trigger depth cannot exceed the buffer minus the trigger slot.
        w_post_clamp = (bus.post_count > CNT_W'(DEPTH-1)) ? CNT_W'(DEPTH-1)
                                                          : bus.post_count;
        w_store_hit  = vec_match(bus.store_cond, bus.signals_in, r_prev, r_prev_valid);
        w_trig_hit   = vec_match(w_stage_cond, bus.signals_in, r_prev, r_prev_valid);
    end

    // Next-state, sequencer and buffer write control.
    always_comb begin
        w_state_nxt      = r_state;
        w_stage_nxt      = r_stage;
        w_wr_addr_nxt    = r_wr_addr;
        w_wrapped_nxt    = r_wrapped;
        w_trig_addr_nxt  = r_trig_addr;
        w_occ_nxt        = r_occ_cnt;
        w_post_nxt       = r_post_cnt;
        w_prev_valid_nxt = r_prev_valid;
        w_wr_en          = 1'b0;

        if (bus.cmd_abort) begin
            w_state_nxt = ST_IDLE;
        end else if (bus.cmd_start) begin
            w_state_nxt      = ST_ARMED;
            w_wr_addr_nxt    = {ADDR_W{1'b0}};
            w_wrapped_nxt    = 1'b0;
            w_stage_nxt      = {SW{1'b0}};
            w_occ_nxt        = {CNT_W{1'b0}};
            w_prev_valid_nxt = 1'b0;
        end else begin
            w_prev_valid_nxt = 1'b1;
            case (r_state)
                ST_ARMED: begin
                    w_wr_en = w_store_hit;
                    if (w_trig_hit) begin
                        if (w_occ_inc >= {1'b0, w_need}) begin
                            if (r_stage == w_eff_last) begin
                                // Trigger sample is stored regardless of store_cond.
                                w_wr_en         = 1'b1;
                                w_trig_addr_nxt = r_wr_addr;
                                w_post_nxt      = w_post_clamp;
                                w_occ_nxt       = {CNT_W{1'b0}};
                                w_state_nxt     = (w_post_clamp == {CNT_W{1'b0}}) ? ST_DONE
                                                                                  : ST_POST;
                            end else begin
                                w_stage_nxt = r_stage + SW'(1);
                                w_occ_nxt   = {CNT_W{1'b0}};
                            end
                        end else begin
                            w_occ_nxt = w_occ_inc[CNT_W-1:0];
                        end
                    end else begin
                        w_occ_nxt = r_occ_cnt;
                    end
                end
                ST_POST: begin
                    if (w_store_hit) begin
                        w_wr_en    = 1'b1;
                        w_post_nxt = r_post_cnt - CNT_W'(1);
                        if (r_post_cnt == CNT_W'(1)) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end else begin
                        w_post_nxt = r_post_cnt;
                    end
                end
                default: begin
                    w_wr_en = 1'b0;
                end
            endcase
        end

        if (w_wr_en) begin
            w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
            if (r_wr_addr == {ADDR_W{1'b1}}) begin
                w_wrapped_nxt = 1'b1;
            end else begin
                w_wrapped_nxt = r_wrapped;
            end
        end else begin
            w_wr_addr_nxt = w_wr_addr_nxt;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state      <= ST_IDLE;
            r_stage      <= {SW{1'b0}};
            r_wr_addr    <= {ADDR_W{1'b0}};
            r_wrapped    <= 1'b0;
            r_trig_addr  <= {ADDR_W{1'b0}};
            r_done       <= 1'b0;
            r_occ_cnt    <= {CNT_W{1'b0}};
            r_post_cnt   <= {CNT_W{1'b0}};
            r_prev       <= {NR_SIGNALS{1'b0}};
            r_prev_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stage      <= w_stage_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wrapped    <= w_wrapped_nxt;
            r_trig_addr  <= w_trig_addr_nxt;
            r_done       <= (w_state_nxt == ST_DONE);
            r_occ_cnt    <= w_occ_nxt;
            r_post_cnt   <= w_post_nxt;
            r_prev       <= bus.signals_in;
            r_prev_valid <= w_prev_valid_nxt;
        end
    end

    // Sample buffer and registered readout; read-before-write on a shared address.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= bus.signals_in;
        end
        r_rd_data <= r_mem[bus.rd_addr];
    end

    assign bus.state     = r_state;
    assign bus.stage     = r_stage;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wrapped   = r_wrapped;
    assign bus.trig_addr = r_trig_addr;
    assign bus.done      = r_done;
    assign bus.rd_data   = r_rd_data;
endmodule

// File: tb/tb_icetap_seq_capture.sv
`timescale 1ns/1ps
module tb_icetap_seq_capture;
    localparam int NS    = 16;
    localparam int NST   = 4;
    localparam int AW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 256;

    logic clk    = 1'b0;
    logic reset_ = 1'b0;
    bit   sig_rand = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    icetap_seq_capture_if #(.NR_SIGNALS(NS), .NR_STAGES(NST), .ADDR_W(AW), .CNT_W(CW)) bus ();

    icetap_seq_capture #(.NR_SIGNALS(NS), .NR_STAGES(NST), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: what the capture engine must look like.
    int            m_state, m_stage, m_wr, m_trig, m_occ, m_post, m_since_arm;
    bit            m_wrapped;
    logic [NS-1:0] m_prev;
    logic [NS-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    logic [NS-1:0] m_rd_exp;
    bit            m_rd_known = 1'b0;
    logic [NS-1:0] m_last_sample;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_match(input logic [3*NS-1:0] cond, input logic [NS-1:0] cur,
                                   input logic [NS-1:0] prv, input bit edge_ok);
        for (int i = 0; i < NS; i++) begin
            int c;
            bit rise, fall;
            c    = int'(cond[3*i +: 3]);
            rise = !prv[i] && cur[i];
            fall = prv[i] && !cur[i];
            if (c == 1 && !cur[i]) return 1'b0;
            if (c == 2 && cur[i]) return 1'b0;
            if (c == 3 && !(edge_ok && rise)) return 1'b0;
            if (c == 4 && !(edge_ok && fall)) return 1'b0;
            if (c == 5 && !(edge_ok && (rise || fall))) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_stage = 0; m_wr = 0; m_trig = 0; m_occ = 0; m_post = 0;
        m_since_arm = 0; m_wrapped = 1'b0; m_prev = '0;
    endtask

    task automatic model_store(input logic [NS-1:0] s);
        m_mem[m_wr]   = s;
        m_known[m_wr] = 1'b1;
        if (m_wr == DEPTH-1) m_wrapped = 1'b1;
        m_wr = (m_wr + 1) % DEPTH;
    endtask

    task automatic model_step();
        logic [NS-1:0] s;
        bit edge_ok, sm, tm, fire;
        int need, eff_last;
        m_rd_exp   = m_mem[bus.rd_addr];
        m_rd_known = m_known[bus.rd_addr];
        if (!reset_) begin
            model_reset();
        end else begin
            s        = bus.signals_in;
            edge_ok  = (m_since_arm > 0);
            eff_last = (int'(bus.last_stage) >= NST) ? NST-1 : int'(bus.last_stage);
            if (bus.cmd_abort) begin
                m_state = 0;
            end else if (bus.cmd_start) begin
                m_state = 1; m_wr = 0; m_wrapped = 1'b0; m_stage = 0; m_occ = 0;
                m_since_arm = -1;
            end else if (m_state == 1) begin
                sm   = m_match(bus.store_cond, s, m_prev, edge_ok);
                tm   = m_match(bus.trig_cond[3*NS*m_stage +: 3*NS], s, m_prev, edge_ok);
                fire = 1'b0;
                if (tm) begin
                    m_occ++;
                    need = int'(bus.trig_count[CW*m_stage +: CW]);
                    if (need == 0) need = 1;
                    if (m_occ >= need) begin
                        if (m_stage == eff_last) fire = 1'b1;
                        else begin m_stage++; m_occ = 0; end
                    end
                end
                if (fire) begin
                    m_trig  = m_wr;
                    m_post  = (int'(bus.post_count) > DEPTH-1) ? DEPTH-1 : int'(bus.post_count);
                    m_state = (m_post != 0) ? 2 : 3;
                    m_occ   = 0;
                end
                if (sm || fire) model_store(s);
            end else if (m_state == 2) begin
                if (m_match(bus.store_cond, s, m_prev, edge_ok)) begin
                    model_store(s);
                    m_post--;
                    if (m_post == 0) m_state = 3;
                end
            end
            if (m_since_arm < 1000) m_since_arm++;
            m_prev        = s;
            m_last_sample = s;
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge reset_);
            model_reset();
        end
    end

    // Probe stimulus: counter from 0 after reset release, or random words.
    initial begin
        bus.signals_in = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_) bus.signals_in = 16'h0000;
            else if (sig_rand) bus.signals_in = 16'($urandom);
            else bus.signals_in = bus.signals_in + 16'h0001;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("state",     32'(bus.state),     32'(m_state));
            chk("stage",     32'(bus.stage),     32'(m_stage));
            chk("wr_addr",   32'(bus.wr_addr),   32'(m_wr));
            chk("wrapped",   32'(bus.wrapped),   32'(m_wrapped));
            chk("trig_addr", 32'(bus.trig_addr), 32'(m_trig));
            chk("done",      32'(bus.done),      32'(m_state == 3));
            if (m_rd_known) chk("rd_data", 32'(bus.rd_data), 32'(m_rd_exp));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_defaults();
        bus.store_cond = '0;
        bus.trig_cond  = '0;
        for (int s = 0; s < NST; s++) bus.trig_count[CW*s +: CW] = 16'd1;
        bus.last_stage = 2'd0;
        bus.post_count = 16'd16;
        bus.rd_addr    = 8'd0;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        tick(2);
        reset_ = 1'b1;
    endtask

    task automatic pulse(input bit s, input bit a);
        bus.cmd_start = s;
        bus.cmd_abort = a;
        tick(1);
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (bus.state !== 2'd3 && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, 32'(bus.state), 32'd3);
    endtask

    task automatic rd_chk(input string name, input int addr, input logic [NS-1:0] exp);
        bus.rd_addr = AW'(addr);
        tick(1);
        chk(name, 32'(bus.rd_data), 32'(exp));
    endtask

    function automatic logic [3*NS-1:0] exact(input logic [NS-1:0] v);
        logic [3*NS-1:0] c;
        for (int i = 0; i < NS; i++) c[3*i +: 3] = v[i] ? 3'd1 : 3'd2;
        return c;
    endfunction

    task automatic rand_config();
        for (int i = 0; i < NS; i++)
            bus.store_cond[3*i +: 3] = ($urandom_range(0, 15) < 14) ? 3'd0 : 3'($urandom_range(1, 7));
        for (int s = 0; s < NST; s++) begin
            for (int i = 0; i < NS; i++)
                bus.trig_cond[3*NS*s + 3*i +: 3] =
                    ($urandom_range(0, 15) < 12) ? 3'd0 : 3'($urandom_range(1, 7));
            bus.trig_count[CW*s +: CW] = 16'($urandom_range(0, 3));
        end
        bus.last_stage = 2'($urandom_range(0, 3));
        bus.post_count = ($urandom_range(0, 7) == 0) ? 16'd300 : 16'($urandom_range(0, 20));
    endtask

    initial begin
        int k;
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        set_defaults();
        tick(3);
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_done",  32'(bus.done),  32'd0);

        // A: exact 0x1c00 trigger, 16 post samples.
        set_defaults();
        bus.trig_cond[0 +: 3*NS] = exact(16'h1c00);
        do_reset();
        pulse(1'b1, 1'b0);
        wait_done("A_done", 8000);
        chk("A_trig_addr", 32'(bus.trig_addr), 32'h00ff);
        for (int j = 0; j <= 16; j++)
            rd_chk("A_rd", (m_trig + j) % DEPTH, 16'h1c00 + 16'(j));

        // B: three rising edges on bit 4, then exact 0x0200.
        set_defaults();
        bus.trig_cond[3*4 +: 3]          = 3'd3;
        bus.trig_count[0 +: CW]          = 16'd3;
        bus.trig_cond[3*NS +: 3*NS]      = exact(16'h0200);
        bus.last_stage                   = 2'd1;
        do_reset();
        pulse(1'b1, 1'b0);
        k = 0;
        while (bus.stage !== 2'd1 && k < 300) begin tick(1); k++; end
        chk("B_stage_wait", 32'(bus.stage), 32'd1);
        chk("B_adv_sample", 32'(m_last_sample), 32'h0050);
        wait_done("B_done", 1000);
        chk("B_trig_addr", 32'(bus.trig_addr), 32'h00ff);
        rd_chk("B_rd_trig", m_trig, 16'h0200);

        // C: store only odd values; trigger sample forced.
        set_defaults();
        bus.store_cond[2:0]         = 3'd1;
        bus.trig_cond[0 +: 3*NS]    = exact(16'h1c00);
        do_reset();
        pulse(1'b1, 1'b0);
        wait_done("C_done", 8000);
        chk("C_trig_addr", 32'(bus.trig_addr), 32'h0000);
        rd_chk("C_rd_trig",  m_trig, 16'h1c00);
        rd_chk("C_rd_prev",  (m_trig + DEPTH - 1) % DEPTH, 16'h1bff);
        rd_chk("C_rd_next1", (m_trig + 1) % DEPTH, 16'h1c01);
        rd_chk("C_rd_next2", (m_trig + 2) % DEPTH, 16'h1c03);

        // D: arm at cycle 20, post 0 -> DONE right after trigger, wrapped.
        set_defaults();
        bus.trig_cond[0 +: 3*NS] = exact(16'h1c00);
        bus.post_count           = 16'd0;
        do_reset();
        tick(20);
        pulse(1'b1, 1'b0);
        wait_done("D_done", 8000);
        chk("D_wrapped",   32'(bus.wrapped),   32'd1);
        chk("D_trig_addr", 32'(bus.trig_addr), 32'h00eb);
        chk("D_wr_addr",   32'(bus.wr_addr),   32'h00ec);
        rd_chk("D_rd_prev", (m_trig + DEPTH - 1) % DEPTH, 16'h1bff);

        // E: abort and start+abort collisions.
        set_defaults();
        bus.trig_cond[0 +: 3*NS] = exact(16'hffff);
        do_reset();
        pulse(1'b1, 1'b0);
        tick(10);
        chk("E_armed", 32'(bus.state), 32'd1);
        pulse(1'b0, 1'b1);
        chk("E_abort_state", 32'(bus.state), 32'd0);
        chk("E_abort_done",  32'(bus.done),  32'd0);
        pulse(1'b1, 1'b1);
        chk("E_both_idle", 32'(bus.state), 32'd0);
        pulse(1'b1, 1'b0);
        tick(5);
        pulse(1'b1, 1'b1);
        chk("E_both_armed", 32'(bus.state), 32'd0);

        // F: asynchronous reset in POST, then re-arm.
        set_defaults();
        bus.trig_cond[0 +: 3*NS] = exact(16'h0100);
        bus.post_count           = 16'd200;
        do_reset();
        pulse(1'b1, 1'b0);
        k = 0;
        while (bus.state !== 2'd2 && k < 600) begin tick(1); k++; end
        chk("F_post_wait", 32'(bus.state), 32'd2);
        tick(5);
        #2;
        reset_ = 1'b0;
        #1;
        chk("F_rst_state",   32'(bus.state),     32'd0);
        chk("F_rst_stage",   32'(bus.stage),     32'd0);
        chk("F_rst_wr_addr", 32'(bus.wr_addr),   32'd0);
        chk("F_rst_wrapped", 32'(bus.wrapped),   32'd0);
        chk("F_rst_trig",    32'(bus.trig_addr), 32'd0);
        chk("F_rst_done",    32'(bus.done),      32'd0);
        tick(2);
        bus.post_count = 16'd16;
        reset_ = 1'b1;
        pulse(1'b1, 1'b0);
        wait_done("F_done", 600);
        chk("F_trig_addr", 32'(bus.trig_addr), 32'h00ff);
        rd_chk("F_rd_trig", m_trig, 16'h0100);

        // G: randomized configurations and probe data.
        sig_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            rand_config();
            pulse(1'b1, 1'b0);
            for (int c = 0; c < 800; c++) begin
                int r;
                bus.rd_addr = AW'($urandom);
                r = $urandom_range(0, 999);
                if (r < 3) pulse(1'b0, 1'b1);
                else if (r < 6) pulse(1'b1, 1'b0);
                else if (r < 8) pulse(1'b1, 1'b1);
                else if ((bus.state == 2'd0 || bus.state == 2'd3) && r < 40) begin
                    rand_config();
                    pulse(1'b1, 1'b0);
                end else tick(1);
            end
        end
        sig_rand = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
